// File: rtl/plc_instr_fetch_pkg.sv
// Shared IL instruction-set constants for the PLC CPU.
// This package holds the opcode encodings and the field widths of an IL word.
// The fetch stage needs only I_JMP. The other opcodes are listed so that the
// encoding table stays in one place.
package plc_instr_fetch_pkg;

    // IL word layout: opcode in the top IL_OPW bits, operand in the rest.
    localparam int IL_DW   = 16;
    localparam int IL_AW   = 12;
    localparam int IL_OPW  = 4;
    localparam int IL_ARGW = IL_DW - IL_OPW;

    // Width of the completed-scan counter.
    localparam int SCAN_CNT_W = 16;

    // Opcode encodings.
    localparam logic [IL_OPW-1:0] I_NOP  = 4'h0;
    localparam logic [IL_OPW-1:0] I_LD   = 4'h1;
    localparam logic [IL_OPW-1:0] I_LDN  = 4'h2;
    localparam logic [IL_OPW-1:0] I_AND  = 4'h3;
    localparam logic [IL_OPW-1:0] I_OR   = 4'h4;
    localparam logic [IL_OPW-1:0] I_XOR  = 4'h5;
    localparam logic [IL_OPW-1:0] I_ST   = 4'h6;
    localparam logic [IL_OPW-1:0] I_JMPC = 4'hB;
    localparam logic [IL_OPW-1:0] I_JMP  = 4'hC;
    localparam logic [IL_OPW-1:0] I_CAL  = 4'hD;
    localparam logic [IL_OPW-1:0] I_RET  = 4'hE;

endpackage

// File: rtl/plc_instr_fetch_if.sv
// Program-memory bus and instruction-register handshake between the fetch
// stage (master) and its memory and execute-stage partners (slave).
interface plc_instr_fetch_if
    import plc_instr_fetch_pkg::*;
#(
    parameter int DW  = IL_DW,
    parameter int AW  = IL_AW,
    parameter int OPW = IL_OPW
);
    logic [AW-1:0]     pm_a;
    logic [DW-1:0]     pm_dq;
    logic              ir_valid;
    logic              ir_ready;
    logic [OPW-1:0]    ir_op;
    logic [DW-OPW-1:0] ir_arg;
    logic [AW-1:0]     ir_pc;

    modport master (
        output pm_a, ir_valid, ir_op, ir_arg, ir_pc,
        input  pm_dq, ir_ready
    );

    modport slave (
        input  pm_a, ir_valid, ir_op, ir_arg, ir_pc,
        output pm_dq, ir_ready
    );
endinterface

// File: rtl/plc_scan_watchdog.sv
// Scan watchdog. It counts the words fetched in the current scan.
// trip asserts combinationally on the increment that brings the count to
// WDOG_MAX. The count saturates there until it is cleared.
module plc_scan_watchdog #(
    parameter int WDOG_MAX = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic trip
);
    localparam int CW = $clog2(WDOG_MAX + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Clear has priority over increment. Saturation keeps a stuck count from wrapping back.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != CW'(WDOG_MAX))) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign trip = inc && (count_reg == CW'(WDOG_MAX - 1));
endmodule

// File: rtl/plc_instr_fetch.sv
// Instruction fetch stage of the PLC CPU. It owns the PC and reads one IL word
// per fetch slot. Unconditional JMPs are resolved here and never reach execute.
// A JMP to END_ADDR closes the scan. The stage counts completed scans and
// faults if a scan runs longer than WDOG_MAX words.
module plc_instr_fetch
    import plc_instr_fetch_pkg::*;
#(
    parameter int            DW         = IL_DW,
    parameter int            AW         = IL_AW,
    parameter int            OPW        = IL_OPW,
    parameter logic [AW-1:0] START_ADDR = '0,
    parameter logic [AW-1:0] END_ADDR   = '1,
    parameter int            WDOG_MAX   = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  redirect,
    input  logic [AW-1:0]         redirect_addr,
    input  logic                  fault_clr,
    output logic                  scan_done,
    output logic [SCAN_CNT_W-1:0] scan_cnt,
    output logic                  fault,
    plc_instr_fetch_if.master     bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SCAN_END,
        S_HALT
    } state_e;

    state_e                  state_reg, state_next;
    logic [AW-1:0]           pc_reg, pc_next;
    logic                    ir_valid_reg, ir_valid_next;
    logic [OPW-1:0]          ir_op_reg;
    logic [DW-OPW-1:0]       ir_arg_reg;
    logic [AW-1:0]           ir_pc_reg;
    logic [SCAN_CNT_W-1:0]   scan_cnt_reg;
    logic                    fault_reg, fault_next;

    logic                    ir_load;
    logic                    cnt_inc;
    logic                    wd_inc;
    logic                    wd_clr;
    logic                    wd_trip;
    logic                    fetch_slot;
    logic [OPW-1:0]          word_op;
    logic [DW-OPW-1:0]       word_arg;
    logic [AW-1:0]           jmp_tgt;
    logic                    is_jmp;
    logic                    is_end_jmp;

    // Decode the word presented at PM_A = PC.
    assign word_op    = bus.pm_dq[DW-1 -: OPW];
    assign word_arg   = bus.pm_dq[DW-OPW-1:0];
    assign jmp_tgt    = word_arg[AW-1:0];
    assign is_jmp     = (word_op == OPW'(I_JMP));
    assign is_end_jmp = is_jmp && (jmp_tgt == END_ADDR);

    // A word is consumed when the IR is free or is being taken this cycle.
    assign fetch_slot = !ir_valid_reg || bus.ir_ready;
    // A redirect discards the word in flight, so that word is not counted.
    assign wd_inc     = (state_reg == S_FETCH) && !redirect && fetch_slot;

    plc_scan_watchdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr),
        .inc   (wd_inc),
        .trip  (wd_trip)
    );

    // Next-state and control decode. A redirect outranks JMP, end-of-scan and watchdog.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_valid_next = ir_valid_reg;
        fault_next    = fault_reg;
        ir_load       = 1'b0;
        cnt_inc       = 1'b0;
        wd_clr        = 1'b0;
        scan_done     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    ir_valid_next = 1'b0;
                    pc_next       = redirect_addr;
                end else if (fetch_slot) begin
                    if (is_end_jmp) begin
                        // End-of-scan beats a watchdog trip on the same word.
                        ir_valid_next = 1'b0;
                        state_next    = S_SCAN_END;
                    end else if (wd_trip) begin
                        fault_next    = 1'b1;
                        ir_valid_next = 1'b0;
                        state_next    = S_HALT;
                    end else if (is_jmp) begin
                        ir_valid_next = 1'b0;
                        pc_next       = jmp_tgt;
                    end else begin
                        ir_load       = 1'b1;
                        ir_valid_next = 1'b1;
                        pc_next       = pc_reg + 1'b1;
                    end
                end
            end
            S_SCAN_END: begin
                if (redirect) begin
                    ir_valid_next = 1'b0;
                    pc_next       = redirect_addr;
                    state_next    = S_FETCH;
                end else begin
                    scan_done  = 1'b1;
                    cnt_inc    = 1'b1;
                    wd_clr     = 1'b1;
                    pc_next    = START_ADDR;
                    state_next = run ? S_FETCH : S_IDLE;
                end
            end
            S_HALT: begin
                ir_valid_next = 1'b0;
                if (fault_clr) begin
                    fault_next = 1'b0;
                    wd_clr     = 1'b1;
                    pc_next    = START_ADDR;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, PC, IR and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            pc_reg       <= START_ADDR;
            ir_valid_reg <= 1'b0;
            ir_op_reg    <= '0;
            ir_arg_reg   <= '0;
            ir_pc_reg    <= '0;
            scan_cnt_reg <= '0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_valid_reg <= ir_valid_next;
            fault_reg    <= fault_next;
            if (ir_load) begin
                ir_op_reg  <= word_op;
                ir_arg_reg <= word_arg;
                ir_pc_reg  <= pc_reg;
            end
            if (cnt_inc) begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.pm_a     = pc_reg;
    assign bus.ir_valid = ir_valid_reg;
    assign bus.ir_op    = ir_op_reg;
    assign bus.ir_arg   = ir_arg_reg;
    assign bus.ir_pc    = ir_pc_reg;
    assign scan_cnt     = scan_cnt_reg;
    assign fault        = fault_reg;
endmodule

// File: tb/tb_plc_instr_fetch.sv
// Directed testbench for plc_instr_fetch. The watchdog limit is 8 words.
module tb_plc_instr_fetch;
    import plc_instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic        redirect = 1'b0;
    logic [11:0] redirect_addr = '0;
    logic        fault_clr = 1'b0;
    logic        scan_done;
    logic [15:0] scan_cnt;
    logic        fault;

    logic [15:0] mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    plc_instr_fetch_if bus ();

    assign bus.pm_dq = mem[bus.pm_a];

    plc_instr_fetch #(
        .WDOG_MAX (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .fault_clr     (fault_clr),
        .scan_done     (scan_done),
        .scan_cnt      (scan_cnt),
        .fault         (fault),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("check %s ok: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    // Hold reset over two edges and leave #1 after an edge with reset released.
    task automatic do_reset();
        run = 1'b0; redirect = 1'b0; fault_clr = 1'b0;
        bus.ir_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_ir(input string tag, input logic [3:0] op, input logic [11:0] arg,
                            input logic [11:0] pc);
        check_eq({tag, "_valid"}, bus.ir_valid, 1'b1);
        check_eq({tag, "_op"}, bus.ir_op, op);
        check_eq({tag, "_arg"}, bus.ir_arg, arg);
        check_eq({tag, "_pc"}, bus.ir_pc, pc);
    endtask

    initial begin
        #1;
        // ---- reset values ----
        do_reset();
        check_eq("rst_ir_valid", bus.ir_valid, 1'b0);
        check_eq("rst_pm_a", bus.pm_a, 12'h000);
        check_eq("rst_ir_op", bus.ir_op, 4'h0);
        check_eq("rst_ir_pc", bus.ir_pc, 12'h000);
        check_eq("rst_scan_cnt", scan_cnt, 16'h0000);
        check_eq("rst_fault", fault, 1'b0);
        check_eq("rst_scan_done", scan_done, 1'b0);

        // ---- 1: basic 3-word scan ----
        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'h4001; mem[2] = 16'hCFFF;
        do_reset();
        run = 1'b1; bus.ir_ready = 1'b1;
        tick(); check_eq("t1_fetch_entry_valid", bus.ir_valid, 1'b0);
        tick(); check_ir("t1_w0", 4'h1, 12'h000, 12'h000);
        check_eq("t1_pm_a1", bus.pm_a, 12'h001);
        tick(); check_ir("t1_w1", 4'h4, 12'h001, 12'h001);
        tick(); check_eq("t1_end_valid", bus.ir_valid, 1'b0);
        check_eq("t1_scan_done", scan_done, 1'b1);
        check_eq("t1_cnt_before", scan_cnt, 16'h0000);
        tick(); check_eq("t1_done_pulse_end", scan_done, 1'b0);
        check_eq("t1_scan_cnt", scan_cnt, 16'h0001);
        check_eq("t1_pm_a_restart", bus.pm_a, 12'h000);
        tick(); check_ir("t1_next_scan", 4'h1, 12'h000, 12'h000);

        // ---- 2: back-pressure at pc1 ----
        tick(); check_ir("t2_w1", 4'h4, 12'h001, 12'h001);
        bus.ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_ir("t2_stall", 4'h4, 12'h001, 12'h001);
            check_eq("t2_stall_pm_a", bus.pm_a, 12'h002);
        end
        bus.ir_ready = 1'b1;
        tick(); check_eq("t2_release_end", scan_done, 1'b1);
        check_eq("t2_release_pm_a", bus.pm_a, 12'h002);

        // ---- 3: JMP 005 never presented ----
        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'h4001; mem[2] = 16'hC005;
        mem[5] = 16'h1002; mem[6] = 16'hCFFF;
        do_reset();
        run = 1'b1; bus.ir_ready = 1'b1;
        tick();
        tick(); check_ir("t3_w0", 4'h1, 12'h000, 12'h000);
        tick(); check_ir("t3_w1", 4'h4, 12'h001, 12'h001);
        tick(); check_eq("t3_jmp_bubble", bus.ir_valid, 1'b0);
        check_eq("t3_jmp_pm_a", bus.pm_a, 12'h005);
        tick(); check_ir("t3_w5", 4'h1, 12'h002, 12'h005);
        tick(); check_eq("t3_end", scan_done, 1'b1);

        // ---- 4: redirect drops held word; redirect beats JMP FFF ----
        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'h4001; mem[2] = 16'hCFFF;
        mem[12'h020] = 16'h4003; mem[12'h021] = 16'hCFFF;
        do_reset();
        run = 1'b1; bus.ir_ready = 1'b0;
        tick();
        tick(); check_ir("t4_held", 4'h1, 12'h000, 12'h000);
        redirect = 1'b1; redirect_addr = 12'h020;
        tick(); redirect = 1'b0;
        check_eq("t4_drop_valid", bus.ir_valid, 1'b0);
        check_eq("t4_redir_pm_a", bus.pm_a, 12'h020);
        bus.ir_ready = 1'b1;
        tick(); check_ir("t4_target", 4'h4, 12'h003, 12'h020);
        check_eq("t4_pm_a_jmp", bus.pm_a, 12'h021);
        redirect = 1'b1; redirect_addr = 12'h000;
        tick(); redirect = 1'b0;
        check_eq("t4_no_done", scan_done, 1'b0);
        check_eq("t4_no_cnt", scan_cnt, 16'h0000);
        check_eq("t4_redir2_pm_a", bus.pm_a, 12'h000);
        tick(); check_ir("t4_after", 4'h1, 12'h000, 12'h000);
        check_eq("t4_still_no_done", scan_done, 1'b0);

        // ---- 5: watchdog on {LD 000, JMP 000} ----
        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'hC000;
        do_reset();
        run = 1'b1; bus.ir_ready = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) tick();
        check_ir("t5_word7", 4'h1, 12'h000, 12'h000);
        check_eq("t5_no_fault_yet", fault, 1'b0);
        tick(); check_eq("t5_fault", fault, 1'b1);
        check_eq("t5_fault_valid", bus.ir_valid, 1'b0);
        tick(); check_eq("t5_halt_sticky", fault, 1'b1);
        check_eq("t5_halt_valid", bus.ir_valid, 1'b0);
        fault_clr = 1'b1; run = 1'b0;
        tick(); fault_clr = 1'b0;
        check_eq("t5_clr_fault", fault, 1'b0);
        check_eq("t5_clr_pm_a", bus.pm_a, 12'h000);
        tick(); check_eq("t5_idle_valid", bus.ir_valid, 1'b0);
        check_eq("t5_idle_pm_a", bus.pm_a, 12'h000);

        // ---- 6: RUN drop completes scan; async reset mid-scan ----
        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'h4001; mem[2] = 16'hCFFF;
        do_reset();
        run = 1'b1; bus.ir_ready = 1'b1;
        tick();
        tick();
        tick(); check_ir("t6_w1", 4'h4, 12'h001, 12'h001);
        run = 1'b0;
        tick(); check_eq("t6_done", scan_done, 1'b1);
        tick(); check_eq("t6_cnt", scan_cnt, 16'h0001);
        check_eq("t6_pm_a", bus.pm_a, 12'h000);
        tick(); check_eq("t6_idle_done", scan_done, 1'b0);
        check_eq("t6_idle_cnt", scan_cnt, 16'h0001);
        check_eq("t6_idle_valid", bus.ir_valid, 1'b0);
        run = 1'b1;
        tick();
        tick(); check_ir("t6_restart", 4'h1, 12'h000, 12'h000);
        rst_n = 1'b0;
        #1;
        check_eq("t6_arst_valid", bus.ir_valid, 1'b0);
        check_eq("t6_arst_op", bus.ir_op, 4'h0);
        check_eq("t6_arst_pm_a", bus.pm_a, 12'h000);
        check_eq("t6_arst_cnt", scan_cnt, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
